// File: rtl/input_conditioner_if.sv
// Pin-side bundle for input_conditioner: raw switches/button in, conditioned
// strobe and captured guess out.
interface input_conditioner_if;
    logic [15:0] SW;
    logic        confirm;
    logic        confirm_pulse;
    logic [15:0] guess;
    logic        guess_valid;
    logic [1:0]  guess_error;

    modport master (
        output SW,
        output confirm,
        input  confirm_pulse,
        input  guess,
        input  guess_valid,
        input  guess_error
    );

    modport slave (
        input  SW,
        input  confirm,
        output confirm_pulse,
        output guess,
        output guess_valid,
        output guess_error
    );
endinterface

// File: rtl/input_conditioner.sv
// Synchronizes switches and confirm button, debounces the button into a single
// strobe per press, and latches the 4-digit guess with its legality check.
//
// state        | meaning
// IDLE         | button released and stable, cnt held at 0
// PRESS_WAIT   | button seen high, counting stable-high cycles
// HELD         | press accepted (pulse issued), waiting for release
// RELEASE_WAIT | button seen low, counting stable-low cycles
module input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clock,
    input  logic                CPU_RESETN,
    input_conditioner_if.slave  pins
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("input_conditioner: SYNC_STAGES must be at least 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("input_conditioner: DEBOUNCE_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] confirm_sync;
    logic [15:0]            sw_sync [SYNC_STAGES];
    logic                   confirm_s;
    logic [15:0]            sw_s;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   pulse_d;

    logic                   non_decimal;
    logic                   repeated;
    logic [1:0]             check_error;

    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            confirm_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sw_sync[i] <= '0;
            end
        end else begin
            confirm_sync <= {confirm_sync[SYNC_STAGES-2:0], pins.confirm};
            sw_sync[0]   <= pins.SW;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sw_sync[i] <= sw_sync[i-1];
            end
        end
    end

    assign confirm_s = confirm_sync[SYNC_STAGES-1];
    assign sw_s      = sw_sync[SYNC_STAGES-1];

    // Non-decimal digits outrank repeats when both are present.
    always_comb begin
        non_decimal = 1'b0;
        repeated    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (sw_s[4*i +: 4] > 4'd9) begin
                non_decimal = 1'b1;
            end
        end
        for (int i = 0; i < 3; i++) begin
            for (int j = i + 1; j < 4; j++) begin
                if (sw_s[4*i +: 4] == sw_s[4*j +: 4]) begin
                    repeated = 1'b1;
                end
            end
        end
        if (non_decimal) begin
            check_error = 2'b01;
        end else if (repeated) begin
            check_error = 2'b10;
        end else begin
            check_error = 2'b00;
        end
    end

    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (confirm_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!confirm_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            HELD: begin
                if (!confirm_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (confirm_s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Capture happens on the same edge that raises the pulse, so the guess
    // is the synchronized switch value seen by the accepting FSM step.
    always_ff @(posedge clock or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pins.confirm_pulse <= 1'b0;
            pins.guess         <= 16'h0000;
            pins.guess_valid   <= 1'b0;
            pins.guess_error   <= 2'b00;
        end else begin
            pins.confirm_pulse <= pulse_d;
            if (pulse_d) begin
                pins.guess       <= sw_s;
                pins.guess_valid <= (check_error == 2'b00);
                pins.guess_error <= check_error;
            end
        end
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: run-length debounce model compared every cycle,
// plus directed scenarios with literal expected values.
module tb_input_conditioner;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic clock = 1'b0;
    logic rst_n = 1'b1;

    input_conditioner_if bus ();

    input_conditioner #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clock      (clock),
        .CPU_RESETN (rst_n),
        .pins       (bus)
    );

    always #5 clock = ~clock;

    int checks    = 0;
    int failures  = 0;
    int edge_cnt  = 0;
    int pulse_cnt = 0;
    int pulse_edge = -1;
    bit cmp_en    = 1'b0;

    // Model state: delay lines for the synchronizers, debounced level and the
    // length of the current run of samples disagreeing with it.
    bit          m_cs  [SYNC];
    logic [15:0] m_sws [SYNC];
    bit          m_level = 1'b0;
    int          m_run   = 0;
    bit          m_pulse = 1'b0;
    logic [15:0] m_guess = 16'h0;
    bit          m_valid = 1'b0;
    logic [1:0]  m_err   = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] legality(input logic [15:0] v);
        int d [4];
        bit dup;
        for (int i = 0; i < 4; i++) d[i] = int'((v >> (4 * i)) & 16'hF);
        for (int i = 0; i < 4; i++) if (d[i] > 9) return 2'b01;
        dup = 1'b0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (i != j && d[i] == d[j]) dup = 1'b1;
        return dup ? 2'b10 : 2'b00;
    endfunction

    always @(posedge clock) edge_cnt++;

    always @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) begin
                m_cs[i]  = 1'b0;
                m_sws[i] = 16'h0;
            end
            m_level = 1'b0;
            m_run   = 0;
            m_pulse = 1'b0;
            m_guess = 16'h0;
            m_valid = 1'b0;
            m_err   = 2'b00;
        end else begin
            m_pulse = 1'b0;
            if (m_cs[SYNC-1] != m_level) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_level = m_cs[SYNC-1];
                    m_run   = 0;
                    if (m_level) begin
                        m_pulse = 1'b1;
                        m_guess = m_sws[SYNC-1];
                        m_err   = legality(m_guess);
                        m_valid = (m_err == 2'b00);
                    end
                end
            end else begin
                m_run = 0;
            end
            for (int i = SYNC - 1; i > 0; i--) begin
                m_cs[i]  = m_cs[i-1];
                m_sws[i] = m_sws[i-1];
            end
            m_cs[0]  = bus.confirm;
            m_sws[0] = bus.SW;
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            check("pulse", 32'(bus.confirm_pulse), 32'(m_pulse));
            check("guess", 32'(bus.guess), 32'(m_guess));
            check("valid", 32'(bus.guess_valid), 32'(m_valid));
            check("error", 32'(bus.guess_error), 32'(m_err));
            if (bus.confirm_pulse === 1'b1) begin
                pulse_cnt++;
                pulse_edge = edge_cnt;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input int hi, input int lo);
        bus.confirm = 1'b1;
        cycles(hi);
        bus.confirm = 1'b0;
        cycles(lo);
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_pulse"}, 32'(bus.confirm_pulse), 32'h0);
        check({tag, "_guess"}, 32'(bus.guess), 32'h0);
        check({tag, "_valid"}, 32'(bus.guess_valid), 32'h0);
        check({tag, "_error"}, 32'(bus.guess_error), 32'h0);
    endtask

    task automatic press_and_check(input logic [15:0] sw, input logic [1:0] err, input string tag);
        int pc;
        bus.SW = sw;
        cycles(4);
        pc = pulse_cnt;
        press(20, 20);
        check({tag, "_pulses"}, 32'(pulse_cnt - pc), 32'd1);
        check({tag, "_guess"}, 32'(bus.guess), 32'(sw));
        check({tag, "_error"}, 32'(bus.guess_error), 32'(err));
        check({tag, "_valid"}, 32'(bus.guess_valid), 32'(err == 2'b00));
    endtask

    initial begin
        int pc;
        int e_ref;
        bit seq [6];

        bus.SW      = 16'h0000;
        bus.confirm = 1'b0;
        #1;

        // 1. Reset with inputs active, then release with button held.
        rst_n       = 1'b0;
        bus.SW      = 16'hFFFF;
        bus.confirm = 1'b1;
        cmp_en      = 1'b1;
        cycles(4);
        outputs_zero("reset");
        rst_n = 1'b1;
        e_ref = edge_cnt + 1;
        pc    = pulse_cnt;
        cycles(14);
        check("reset_release_pulses", 32'(pulse_cnt - pc), 32'd1);
        check("reset_release_edge", 32'(pulse_edge - e_ref), 32'd6);
        check("reset_release_error", 32'(bus.guess_error), 32'h1);
        bus.confirm = 1'b0;
        cycles(20);

        // 2. Clean legal press, then guess holds across switch changes.
        press_and_check(16'h1234, 2'b00, "legal");
        bus.SW = 16'h9999;
        cycles(10);
        check("legal_hold_guess", 32'(bus.guess), 32'h1234);
        check("legal_hold_valid", 32'(bus.guess_valid), 32'h1);

        // 3. Illegal guesses.
        press_and_check(16'h12A4, 2'b01, "nondec");
        press_and_check(16'h1231, 2'b10, "repeat");
        press_and_check(16'h11A1, 2'b01, "priority");
        press_and_check(16'h0000, 2'b10, "zeros");

        // 4. Press bounce.
        bus.SW = 16'h3456;
        cycles(4);
        seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        pc  = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            bus.confirm = seq[i];
            cycles(1);
        end
        bus.confirm = 1'b1;
        e_ref = edge_cnt + 1;
        cycles(12);
        check("bounce_pulses", 32'(pulse_cnt - pc), 32'd1);
        check("bounce_edge", 32'(pulse_edge - e_ref), 32'd6);
        check("bounce_guess", 32'(bus.guess), 32'h3456);
        bus.confirm = 1'b0;
        cycles(20);

        // 5. Release bounce from HELD, then a second clean press.
        pc = pulse_cnt;
        bus.confirm = 1'b1;
        cycles(12);
        seq[0] = 1'b0; seq[1] = 1'b0; seq[2] = 1'b1; seq[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.confirm = seq[i];
            cycles(1);
        end
        bus.confirm = 1'b0;
        cycles(10);
        check("release_bounce_pulses", 32'(pulse_cnt - pc), 32'd1);
        press_and_check(16'h5678, 2'b00, "second");

        // 6. Reset mid-press with cnt at 2.
        bus.SW = 16'h9870;
        cycles(4);
        pc = pulse_cnt;
        bus.confirm = 1'b1;
        cycles(4);
        #2;
        rst_n = 1'b0;
        bus.confirm = 1'b0;
        cycles(1);
        outputs_zero("midreset");
        cycles(2);
        #2;
        rst_n = 1'b1;
        cycles(20);
        check("midreset_pulses", 32'(pulse_cnt - pc), 32'd0);
        outputs_zero("midreset_after");
        press_and_check(16'h9870, 2'b00, "after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
